v74x139_dec_reg: RTL and testbench
==================================

Name: v74x139_dec_reg

Overview:
Registered single-section equivalent of one half of a 74x139 dual 2-to-4 decoder. It has an active-low enable and active-low one-hot outputs. It sits in glue logic wherever a 2-bit select must drive one of four active-low strobes. The block is synchronous to one clock and adds one register stage on the outputs.

Parameters:
- OUT_REG, 1, 1 = outputs registered (one-cycle latency); 0 = outputs purely combinational from inputs (CLK/RESET_L unused except that reset still forces outputs inactive).

Ports:
- CLK  input  1  system clock, rising-edge active
- RESET_L  input  1  asynchronous, active-low reset
- G_L  input  1  active-low enable
- A  input  1  select bit 0 (LSB)
- B  input  1  select bit 1 (MSB)
- Y0_L  output  1  active-low decode of B,A = 0,0
- Y1_L  output  1  active-low decode of B,A = 0,1
- Y2_L  output  1  active-low decode of B,A = 1,0
- Y3_L  output  1  active-low decode of B,A = 1,1

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Select index is sel = {B,A}. B is the MSB and A is the LSB.
- Decode function:
  - G_L=1: all Y*_L = 1.
  - G_L=0: Y<sel>_L = 0; the other three outputs = 1.
  - Exactly zero or one output is low at any time.
- OUT_REG=1:
  - Decode is computed combinationally from G_L, A, B.
  - The result is captured into four output flops on the rising edge of CLK.
  - Outputs reflect inputs sampled at the previous rising edge, i.e. one-cycle latency.
  - No glitches on the outputs.
- Reset:
  - RESET_L=0 immediately (asynchronously) forces all Y*_L = 1, independent of CLK.
  - Outputs hold at 1 while reset is asserted.
  - After deassertion, the first rising edge loads the decode of the current inputs.
  - Reset asserted mid-operation overrides any active output at once.
- OUT_REG=0:
  - Outputs follow the decode function combinationally.
  - RESET_L=0 still gates all outputs to 1.
- Inputs X/Z: no requirement. Inputs are assumed to be driven to 0/1.
- There is no other state, no handshake and no FSM.

Decomposition:
- Shared package v74x139_pkg:
  - Constant Y_INACTIVE = 4'b1111.
  - Function or constant table mapping the 2-bit sel to a 4-bit active-low one-hot vector.
- Sub-module dec2to4_l: purely combinational.
  - Inputs: g_l, 2-bit sel.
  - Output: 4-bit active-low vector.
- Top level: instantiates dec2to4_l, adds the output register and async reset, and splits the vector to Y0_L..Y3_L.

Test Plan:
1. RESET_L=0 with G_L=0, A=0, B=0 applied → all Y*_L=1 immediately, and still 1 after several clocks. Release reset → after the next rising edge, Y0_L=0 and Y1_L..Y3_L=1.
2. G_L=0, sweep (A,B) = (0,0), (0,1), (1,0), (1,1), holding each for ≥2 clocks → one cycle after each change: Y0_L, Y2_L, Y1_L, Y3_L low respectively, others 1.
3. G_L=1 with all four (A,B) combinations → Y0_L..Y3_L = 1 on every cycle.
4. Enable toggle: A=1, B=1, G_L switches 0→1→0 on consecutive cycles → Y3_L goes 0, 1, 0, each one cycle after its input. Other outputs stay 1.
5. Mid-operation reset: Y2_L=0 (A=0, B=1, G_L=0), assert RESET_L=0 between clock edges → Y2_L=1 before the next edge. Deassert → Y2_L=0 after the first following rising edge.
6. OUT_REG=0 build: the sweep of scenario 2 → outputs change in the same cycle as the inputs, no clock needed. RESET_L=0 forces 4'b1111.

Source files
------------

// File: rtl/v74x139_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : v74x139_pkg
//  Description : Shared constants and decode helper for the registered
//                74x139-style 2-to-4 active-low decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package v74x139_pkg;

  // All four strobes deasserted (active-low outputs).
  localparam logic [3:0] Y_INACTIVE = 4'b1111;

  // Map a 2-bit select to an active-low one-hot vector (bit n low for sel==n).
  function automatic logic [3:0] dec_onehot_l(input logic [1:0] sel);
    logic [3:0] onehot;
    onehot = 4'b0001 << sel;
    return ~onehot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/v74x139_dec_reg_dec2to4_l.sv
`default_nettype none
// ============================================================================
//  Module      : dec2to4_l
//  Description : Purely combinational 2-to-4 decoder with active-low enable
//                and active-low one-hot outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec2to4_l
  import v74x139_pkg::*;
(
  input  logic       g_l,
  input  logic [1:0] sel,
  output logic [3:0] y_l
);

  // Disabled -> every strobe inactive; enabled -> only the selected one low.
  always_comb begin
    y_l = Y_INACTIVE;
    if (!g_l) begin
      y_l = dec_onehot_l(sel);
    end
  end

endmodule
`default_nettype wire

// File: rtl/v74x139_dec_reg.sv
`default_nettype none
// ============================================================================
//  Module      : v74x139_dec_reg
//  Description : One section of a 74x139 dual 2-to-4 decoder with optional
//                output register and asynchronous active-low reset that
//                forces all strobes inactive.
//  Revision    : 1.0 - initial release
// ============================================================================
module v74x139_dec_reg
  import v74x139_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic CLK,
  input  logic RESET_L,
  input  logic G_L,
  input  logic A,
  input  logic B,
  output logic Y0_L,
  output logic Y1_L,
  output logic Y2_L,
  output logic Y3_L
);

  logic [3:0] dec_y_l;
  logic [3:0] y_l;

  // B is the select MSB, A the LSB.
  dec2to4_l u_dec (
    .g_l (G_L),
    .sel ({B, A}),
    .y_l (dec_y_l)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [3:0] y_d;
      logic [3:0] y_q;

      // Next output state is simply the current decode.
      always_comb begin
        y_d = dec_y_l;
      end

      // Output flops give glitch-free strobes; reset forces them inactive at once.
      always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
          y_q <= Y_INACTIVE;
        end else begin
          y_q <= y_d;
        end
      end

      assign y_l = y_q;
    end else begin : g_out_comb
      // Unregistered path: reset still gates every strobe inactive.
      always_comb begin
        y_l = Y_INACTIVE;
        if (RESET_L) begin
          y_l = dec_y_l;
        end
      end
    end
  endgenerate

  assign Y0_L = y_l[0];
  assign Y1_L = y_l[1];
  assign Y2_L = y_l[2];
  assign Y3_L = y_l[3];

endmodule
`default_nettype wire

// File: tb/tb_v74x139_dec_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_v74x139_dec_reg
//  Description : Scoreboard bench for v74x139_dec_reg, covering the
//                registered build and the combinational build side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_v74x139_dec_reg;

  logic clk;
  logic rst_l;
  logic g_l;
  logic a;
  logic b;

  logic r0, r1, r2, r3;   // registered build outputs
  logic c0, c1, c2, c3;   // combinational build outputs

  int checks;
  int errors;
  int step_no;

  typedef struct {
    logic [3:0] exp_reg;
    logic [3:0] exp_comb;
    int         step;
  } exp_t;

  exp_t exp_q[$];

  v74x139_dec_reg #(.OUT_REG(1)) u_dut_reg (
    .CLK     (clk),
    .RESET_L (rst_l),
    .G_L     (g_l),
    .A       (a),
    .B       (b),
    .Y0_L    (r0),
    .Y1_L    (r1),
    .Y2_L    (r2),
    .Y3_L    (r3)
  );

  v74x139_dec_reg #(.OUT_REG(0)) u_dut_comb (
    .CLK     (clk),
    .RESET_L (rst_l),
    .G_L     (g_l),
    .A       (a),
    .B       (b),
    .Y0_L    (c0),
    .Y1_L    (c1),
    .Y2_L    (c2),
    .Y3_L    (c3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are sampled on the falling edge, away from the capture edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if ({r3, r2, r1, r0} !== e.exp_reg) begin
        errors = errors + 1;
        $display("FAIL reg_out step %0d: got Y3..Y0=%b expected %b",
                 e.step, {r3, r2, r1, r0}, e.exp_reg);
      end
      checks = checks + 1;
      if ({c3, c2, c1, c0} !== e.exp_comb) begin
        errors = errors + 1;
        $display("FAIL comb_out step %0d: got Y3..Y0=%b expected %b",
                 e.step, {c3, c2, c1, c0}, e.exp_comb);
      end
    end
  end

  // Drive one vector just after a rising edge and record what both builds
  // must show at the following falling edge (expected values hand-derived).
  task automatic step(input logic s_rst, input logic s_g, input logic s_a,
                      input logic s_b, input logic [3:0] er, input logic [3:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_l = s_rst;
    g_l   = s_g;
    a     = s_a;
    b     = s_b;
    e.exp_reg  = er;
    e.exp_comb = ec;
    e.step     = step_no;
    exp_q.push_back(e);
    step_no = step_no + 1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    rst_l = 1'b0;
    g_l   = 1'b0;
    a     = 1'b0;
    b     = 1'b0;

    //    rst g  a  b   reg      comb
    // Reset held with Y0 selected, then released.
    step(0, 0, 0, 0, 4'b1111, 4'b1111);
    step(0, 0, 0, 0, 4'b1111, 4'b1111);
    step(0, 0, 0, 0, 4'b1111, 4'b1111);
    step(1, 0, 0, 0, 4'b1111, 4'b1110);
    step(1, 0, 0, 0, 4'b1110, 4'b1110);
    // Enabled sweep (A,B) = 00, 01, 10, 11, two cycles each.
    step(1, 0, 0, 0, 4'b1110, 4'b1110);
    step(1, 0, 0, 1, 4'b1110, 4'b1011);
    step(1, 0, 0, 1, 4'b1011, 4'b1011);
    step(1, 0, 1, 0, 4'b1011, 4'b1101);
    step(1, 0, 1, 0, 4'b1101, 4'b1101);
    step(1, 0, 1, 1, 4'b1101, 4'b0111);
    step(1, 0, 1, 1, 4'b0111, 4'b0111);
    // Disabled with every select combination.
    step(1, 1, 0, 0, 4'b0111, 4'b1111);
    step(1, 1, 0, 1, 4'b1111, 4'b1111);
    step(1, 1, 1, 0, 4'b1111, 4'b1111);
    step(1, 1, 1, 1, 4'b1111, 4'b1111);
    // Enable toggling with sel = 3.
    step(1, 0, 1, 1, 4'b1111, 4'b0111);
    step(1, 1, 1, 1, 4'b0111, 4'b1111);
    step(1, 0, 1, 1, 4'b1111, 4'b0111);
    // Y2 active, then reset asserted between edges.
    step(1, 0, 0, 1, 4'b0111, 4'b1011);
    step(1, 0, 0, 1, 4'b1011, 4'b1011);
    step(0, 0, 0, 1, 4'b1111, 4'b1111);
    step(0, 0, 0, 1, 4'b1111, 4'b1111);
    step(1, 0, 0, 1, 4'b1111, 4'b1011);
    step(1, 0, 0, 1, 4'b1011, 4'b1011);
    step(1, 1, 0, 0, 4'b1011, 4'b1111);
    step(1, 1, 0, 0, 4'b1111, 4'b1111);

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    if (checks != 54) begin
      errors = errors + 1;
      $display("FAIL check_count: got %0d comparisons expected 54", checks);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
